// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with valid/ready request and result handshakes
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] bus_a,
    input  logic [DATA_WIDTH-1:0] bus_b,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic          neg_q, neg_d;
    logic [W-1:0]  dvs_q, dvs_d;     // multiplicand (mul) or divisor (div) magnitude
    logic [W-1:0]  hi_q, hi_d;       // product high word / partial remainder
    logic [W-1:0]  lo_q, lo_d;       // multiplier shifting out / quotient shifting in
    logic [W-1:0]  result_q, result_d;

    // Operand decode at the accept edge: magnitudes, final sign, special cases
    logic          a_neg, b_neg, signed_a, signed_b, is_div;
    logic          div_zero, div_ovf, accept;
    logic [W-1:0]  op_a, op_b;
    logic          neg_in;

    always_comb begin
        is_div   = funct3[2];
        a_neg    = bus_a[W-1];
        b_neg    = bus_b[W-1];
        signed_a = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU)
                 || (funct3 == OP_DIV) || (funct3 == OP_REM);
        signed_b = (funct3 == OP_MUL) || (funct3 == OP_MULH)
                 || (funct3 == OP_DIV) || (funct3 == OP_REM);
        op_a     = (signed_a && a_neg) ? (~bus_a + 1'b1) : bus_a;
        op_b     = (signed_b && b_neg) ? (~bus_b + 1'b1) : bus_b;
        // Remainder follows the dividend; everything else follows the xor of signed operands
        if (funct3 == OP_REM) begin
            neg_in = a_neg;
        end else begin
            neg_in = (signed_a && a_neg) ^ (signed_b && b_neg);
        end
        div_zero = is_div && (bus_b == '0);
        div_ovf  = ((funct3 == OP_DIV) || (funct3 == OP_REM))
                 && (bus_a == MOST_NEG) && (bus_b == ALL_ONES);
        accept   = in_valid && (state_q == S_IDLE) && !flush;
    end

    // One shift-add / restoring-subtract step on the working registers
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;

    always_comb begin
        mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, dvs_q}) : {1'b0, hi_q};
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, dvs_q};
    end

    // Sign correction applied in FIX
    logic [2*W-1:0] prod_raw, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        prod_raw = {hi_q, lo_q};
        prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = neg_q ? (~hi_q + 1'b1) : hi_q;
        if (op_q[2]) begin
            fix_result = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == OP_MUL) begin
            fix_result = prod_fix[W-1:0];
        end else begin
            fix_result = prod_fix[2*W-1:W];
        end
    end

    // Next-state and datapath update; flush overrides everything but reset
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_d  = funct3;
                        neg_d = neg_in;
                        if (div_zero) begin
                            result_d = funct3[1] ? bus_a : ALL_ONES;
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = funct3[1] ? '0 : MOST_NEG;
                            state_d  = S_DONE;
                        end else begin
                            hi_d    = '0;
                            cnt_d   = CNT_INIT;
                            state_d = S_CALC;
                            if (is_div) begin
                                lo_d  = op_a;
                                dvs_d = op_b;
                            end else begin
                                lo_d  = op_b;
                                dvs_d = op_a;
                            end
                        end
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q - 1'b1;
                    if (op_q[2]) begin
                        if (!div_diff[W]) begin
                            hi_d = div_diff[W-1:0];
                            lo_d = {lo_q[W-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[W-1:0];
                            lo_d = {lo_q[W-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[W:1];
                        lo_d = {mul_sum[0], lo_q[W-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = fix_result;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            dvs_q    <= dvs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] bus_a = '0;
    logic [31:0] bus_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] A_DEF = 32'hFFFFF6A0;
    localparam logic [31:0] B_DEF = 32'hFFFFFFF4;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue a request, wait for out_valid and check latency, handshake flags and result
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input logic consume);
        int  lat;
        logic hs_ok;
        @(negedge clk);
        funct3 = f; bus_a = a; bus_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; funct3 = 3'd0; bus_a = 32'h12345678; bus_b = 32'h0;
        lat = 1; hs_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready || !busy) hs_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, {31'd0, hs_ok && busy && !in_ready}, 32'd1);
        check({tag, "_res"}, result, exp);
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
        end
    endtask

    initial begin
        logic [31:0] held;
        logic        stable, seen;

        #1 check("rst_outs", {28'd0, in_ready, busy, out_valid, 1'b0}, 32'b1000);
        check("rst_result", result, 32'h0);
        #12 rstN = 1'b1;

        // Multiplies
        run_op("mul",   3'd0, A_DEF, B_DEF, 32'h00007080, 34, 1'b1);
        run_op("mulh",  3'd1, A_DEF, B_DEF, 32'h00000000, 34, 1'b1);
        run_op("mulhu", 3'd3, A_DEF, B_DEF, 32'hFFFFF694, 34, 1'b1);

        // Divides
        run_op("div",   3'd4, A_DEF, B_DEF, 32'h000000C8, 34, 1'b1);
        run_op("rem",   3'd6, A_DEF, B_DEF, 32'h00000000, 34, 1'b1);
        run_op("divu",  3'd5, A_DEF, B_DEF, 32'h00000000, 34, 1'b1);
        run_op("remu",  3'd7, A_DEF, B_DEF, 32'hFFFFF6A0, 34, 1'b1);

        // Fast path
        run_op("div0",  3'd4, 32'd7, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
        run_op("rem0",  3'd6, 32'd7, 32'd0, 32'h00000007, 1, 1'b1);
        run_op("divov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1);
        run_op("remov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1);

        // Backpressure: result held while out_ready is low
        run_op("bp", 3'd0, A_DEF, B_DEF, 32'h00007080, 34, 1'b0);
        held = result; stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || result !== held || in_ready) stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

        // flush together with in_valid in IDLE does not accept
        @(negedge clk);
        funct3 = 3'd0; bus_a = A_DEF; bus_b = B_DEF; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_noacc", {31'd0, busy}, 32'd0);

        // flush mid-calculation at edge T+10
        @(negedge clk);
        funct3 = 3'd4; bus_a = A_DEF; bus_b = B_DEF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {30'd0, in_ready, busy}, 32'b10);
        check("flush_result", result, 32'h00007080);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_noout", {31'd0, seen}, 32'd0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 34, 1'b1);

        // Asynchronous reset during CALC
        @(negedge clk);
        funct3 = 3'd0; bus_a = A_DEF; bus_b = B_DEF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 rstN = 1'b0;
        #1 check("arst_outs", {29'd0, in_ready, busy, out_valid}, 32'b100);
        check("arst_result", result, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        run_op("mul_post", 3'd0, 32'd134, 32'd12, 32'h00000648, 34, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: simulation did not finish");
    end
endmodule
